// File: rtl/median_stream_filter.sv
// rtl/median_stream_filter.sv - sliding-window median filter with valid/ready streams
module median_stream_filter #(
    parameter int DATA_W = 4,
    parameter int WIN    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);
    localparam int CNT_W = $clog2(WIN + 1);

    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_win      [WIN];
    logic [DATA_W-1:0] w_win_next [WIN];
    logic [DATA_W-1:0] w_median;
    logic              w_accept;
    logic              w_fill_last;
    logic              w_emit;

    if (WIN != 3 && WIN != 5) begin : g_bad_win
        $error("median_stream_filter: WIN must be 3 or 5");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_FILL;
        end else if (r_state == S_FILL && w_accept && w_fill_last) begin
            w_state_next = S_RUN;
        end
    end

    // A median is produced for every accept that leaves the window full.
    always_comb begin
        in_ready    = rst_n && !flush && (!out_valid || out_ready);
        w_accept    = in_valid && in_ready;
        w_fill_last = (r_cnt == CNT_W'(WIN - 1));
        w_emit      = w_accept && ((r_state == S_RUN) || w_fill_last);
    end

    always_comb begin
        w_win_next[0] = in_data;
        for (int i = 1; i < WIN; i++) begin
            w_win_next[i] = r_win[i-1];
        end
    end

    if (WIN == 3) begin : g_med3
        logic [DATA_W-1:0] w_ab_lo;
        logic [DATA_W-1:0] w_ab_hi;
        logic [DATA_W-1:0] w_hc_lo;

        always_comb begin
            w_ab_lo  = (w_win_next[0] < w_win_next[1]) ? w_win_next[0] : w_win_next[1];
            w_ab_hi  = (w_win_next[0] < w_win_next[1]) ? w_win_next[1] : w_win_next[0];
            w_hc_lo  = (w_ab_hi < w_win_next[2]) ? w_ab_hi : w_win_next[2];
            w_median = (w_ab_lo > w_hc_lo) ? w_ab_lo : w_hc_lo;
        end
    end else begin : g_med5
        // Optimal 9-comparator sorting network; the median lands in slot 2.
        localparam int CX_N = 9;
        localparam int CX_A [CX_N] = '{0, 3, 2, 2, 1, 0, 0, 1, 1};
        localparam int CX_B [CX_N] = '{1, 4, 4, 3, 4, 3, 2, 3, 2};

        logic [DATA_W-1:0] w_srt [5];
        logic [DATA_W-1:0] w_tmp;

        always_comb begin
            w_tmp = '0;
            for (int i = 0; i < 5; i++) begin
                w_srt[i] = w_win_next[i];
            end
            for (int k = 0; k < CX_N; k++) begin
                if (w_srt[CX_A[k]] > w_srt[CX_B[k]]) begin
                    w_tmp           = w_srt[CX_A[k]];
                    w_srt[CX_A[k]]  = w_srt[CX_B[k]];
                    w_srt[CX_B[k]]  = w_tmp;
                end
            end
            w_median = w_srt[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < WIN; i++) begin
                r_win[i] <= '0;
            end
        end else if (flush) begin
            r_cnt     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_win <= w_win_next;
                if (r_cnt != CNT_W'(WIN)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_emit) begin
                out_valid <= 1'b1;
                out_data  <= w_median;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_median_stream_filter.sv
// tb/tb_median_stream_filter.sv - scoreboard bench for median_stream_filter, WIN=3 and WIN=5
module tb_median_stream_filter;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready3, out_valid3;
    logic [3:0] out_data3;
    logic       in_ready5, out_valid5;
    logic [3:0] out_data5;

    logic [3:0] h3[$], h5[$], q3[$], q5[$];
    bit         ov3, ov5, rdy3_x, rdy5_x, ov3_x, ov5_x;
    bit         done;
    int         checks;
    int         errors;

    median_stream_filter #(.DATA_W(4), .WIN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready)
    );

    median_stream_filter #(.DATA_W(4), .WIN(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_median(input logic [3:0] h[$]);
        logic [3:0] s[$];
        s = h;
        s.sort();
        return s[s.size() / 2];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: window history as a queue, median by sorting.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            h3.delete(); q3.delete(); ov3 = 0; rdy3_x = 0; ov3_x = 0;
            h5.delete(); q5.delete(); ov5 = 0; rdy5_x = 0; ov5_x = 0;
        end else begin
            ov3_x  = ov3;
            rdy3_x = !flush && (!ov3 || out_ready);
            if (flush) begin
                h3.delete(); ov3 = 0;
            end else begin
                if (ov3 && out_ready) ov3 = 0;
                if (in_valid && rdy3_x) begin
                    h3.push_front(in_data);
                    if (h3.size() > 3) void'(h3.pop_back());
                    if (h3.size() == 3) begin q3.push_back(ref_median(h3)); ov3 = 1; end
                end
            end
            ov5_x  = ov5;
            rdy5_x = !flush && (!ov5 || out_ready);
            if (flush) begin
                h5.delete(); ov5 = 0;
            end else begin
                if (ov5 && out_ready) ov5 = 0;
                if (in_valid && rdy5_x) begin
                    h5.push_front(in_data);
                    if (h5.size() > 5) void'(h5.pop_back());
                    if (h5.size() == 5) begin q5.push_back(ref_median(h5)); ov5 = 1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            chk("rst_in_ready3", in_ready3, 0);
            chk("rst_out_valid3", out_valid3, 0);
            chk("rst_out_data3", out_data3, 0);
            chk("rst_in_ready5", in_ready5, 0);
            chk("rst_out_valid5", out_valid5, 0);
            chk("rst_out_data5", out_data5, 0);
        end else begin
            chk("in_ready3", in_ready3, rdy3_x);
            chk("out_valid3", out_valid3, ov3_x);
            if (ov3_x) begin
                chk("q3_pending", q3.size() > 0, 1);
                if (q3.size() > 0) begin
                    chk("out_data3", out_data3, q3[0]);
                    if (out_ready || flush) void'(q3.pop_front());
                end
            end
            chk("in_ready5", in_ready5, rdy5_x);
            chk("out_valid5", out_valid5, ov5_x);
            if (ov5_x) begin
                chk("q5_pending", q5.size() > 0, 1);
                if (q5.size() > 0) begin
                    chk("out_data5", out_data5, q5[0]);
                    if (out_ready || flush) void'(q5.pop_front());
                end
            end
        end
        if (done) begin
            chk("q3_drained", q3.size(), 0);
            chk("q5_drained", q5.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic drive(input bit v, input logic [3:0] d, input bit ordy, input bit fl);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic send(input logic [3:0] d);
        drive(1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, 4'd0, 1'b1, 1'b1);
    endtask

    initial begin
        checks = 0; errors = 0; done = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        send(5); send(1); send(9); send(3); send(3); send(15); idle(2);
        do_flush();
        send(7); send(2); send(9); send(4); send(1); send(8); idle(2);
        do_flush();
        send(10); send(10); send(10); send(0); idle(2);
        do_flush();
        send(15); send(0); send(15); idle(2);
        do_flush();

        send(1); send(2); send(3);
        repeat (4) drive(1'b1, 4'd2, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 1'b1, 1'b0);
        idle(3);

        send(4); send(5); send(6);
        drive(1'b1, 4'd6, 1'b1, 1'b1);
        send(1); send(2); idle(1); send(3); idle(2);

        send(4); send(5); send(6); send(7);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'd9;
        @(negedge clk);
        send(1); send(8); send(3); send(12); send(11); idle(2);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(299) != 0);
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 4'($urandom_range(15));
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(39) == 0);
        end

        idle(4);
        done = 1;
        repeat (10) @(negedge clk);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end
endmodule

// File: doc/median_stream_filter.md
Name: median_stream_filter

Overview:
- Sequential, streaming counterpart to the combinational 3-number median finder.
- Accepts one DATA_W-bit sample per handshake and maintains a sliding window of the last WIN samples.
- Once the window is full, emits the median of the window for every accepted sample.
- Sits between a sample source and a downstream consumer, with valid/ready on both sides.

Parameters:
- DATA_W, 4: sample width in bits, unsigned.
- WIN, 3: window length. Legal values are 3 or 5; any other value is a compile-time error.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous window clear, one-cycle pulse or level.
- in_valid  input  1  source presents in_data.
- in_data  input  DATA_W  sample, unsigned.
- in_ready  output  1  block can accept a sample this cycle.
- out_valid  output  1  out_data holds a median.
- out_data  output  DATA_W  median of the last WIN accepted samples.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset: asynchronous on rst_n low. All state clears immediately and is held while rst_n is low:
  - window registers = 0
  - fill count = 0
  - out_valid = 0
  - out_data = 0
  - in_ready = 0
- After rst_n rises, in_ready follows the rule below from the next evaluation.
- Handshakes:
  - in_ready = !flush && (!out_valid || out_ready).
  - A sample is accepted when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Window: shift register w[0..WIN-1], where w[0] is the newest sample. On accept, w[i] <= w[i-1] and w[0] <= in_data.
- Fill count: cnt ranges 0..WIN and saturates at WIN. It increments on accept while cnt < WIN.
- FSM with states FILL and RUN:
  - FILL covers cnt < WIN.
  - FILL -> RUN on the accept that makes cnt == WIN.
  - RUN -> FILL only on flush or reset.
- Output generation:
  - On an accept that leaves cnt == WIN (either the filling accept or any accept in RUN), set out_valid <= 1 on the next clock edge.
  - out_data takes the median of the updated window, i.e. including the new sample.
  - Latency is 1 cycle from accept to out_valid.
  - Accepts in FILL that leave cnt < WIN produce no output.
  - out_valid clears on transfer unless a new accept occurs in the same cycle. In that case the new median replaces the old one, giving full throughput of 1 sample/cycle with out_ready held high.
- Median arithmetic: unsigned compare; ties are legal, and duplicates count as distinct entries.
  - WIN=3: median of three via min/max compare stages.
  - WIN=5: third-smallest of five via a compare-exchange network.
  - The median is purely combinational from the next-window value, registered into out_data. No width growth.
- flush has priority over everything except reset:
  - clears cnt to 0, enters FILL, clears out_valid (a pending median is dropped).
  - window contents need not clear.
  - in_ready = 0 during flush, so a simultaneous in_valid sample is not accepted; the source must hold it.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and the window is frozen. No sample is lost or duplicated.
- Reset mid-stream: discards the window and any pending output. The first out_valid after reset requires WIN fresh accepts.

Test Plan:
- WIN=3, out_ready=1, stream 5,1,9,3,3,15 back-to-back -> out_valid first asserts 1 cycle after the 3rd accept. Outputs are 5,3,3,3, one per cycle with no gaps.
- WIN=5, stream 7,2,9,4,1,8 -> exactly two outputs: 4 (window 7,2,9,4,1), then 4 (window 2,9,4,1,8).
- WIN=3, stream 10,10,10 then 0 -> outputs 10, then 10 (median of 10,10,0). Also check extremes: 15,0,15 -> 15.
- Backpressure: WIN=3, after the first output hold out_ready=0 for 4 cycles while in_valid=1 with data 2 -> out_data stays constant and in_ready=0. Releasing out_ready resumes the stream with the next median computed from the held sample 2.
- Flush: after RUN, pulse flush together with in_valid=1 and data 6 -> that sample is not accepted and out_valid drops. Then send 1,2 -> no output; send 3 -> output 2.
- Reset: assert rst_n low asynchronously mid-stream, between clock edges -> all outputs go to 0 immediately. After release, no out_valid until WIN new samples are accepted.
